// File: rtl/nonce_block_builder.sv
// nonce_block_builder: fetches header words from an upstream memory, then for
// each word offers {header, nonce} to a hash core with nonce counting up from 0.
// It stops on the first digest whose top byte is below target, or when the
// nonce reaches NONCE_LIMIT. A done pulse marks the end of the last word.
module nonce_block_builder #(
    parameter logic [31:0] NONCE_LIMIT = 32'h0000_00FF,
    parameter int          NUM_WORDS   = 4
) (
    input  logic         clk,
    input  logic         reset_L,
    input  logic         start,
    input  logic [95:0]  entrada,
    input  logic         hash_ready,
    input  logic         hash_done,
    input  logic [23:0]  hash_out,
    input  logic [7:0]   target,
    output logic [1:0]   rd_ptr,
    output logic [127:0] bloque_in,
    output logic         bloque_valid,
    output logic [31:0]  nonce_out,
    output logic         found,
    output logic         done,
    output logic         busy
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        ISSUE,
        WAIT,
        CHECK,
        FINISH
    } state_t;

    localparam logic [1:0] LAST_PTR = 2'(NUM_WORDS - 1);

    state_t        state_q, state_d;
    logic [1:0]    rd_ptr_q, rd_ptr_d;
    logic [31:0]   nonce_q, nonce_d;
    logic [95:0]   header_q, header_d;
    logic [7:0]    hash_q, hash_d;
    logic [31:0]  nonce_out_q, nonce_out_d;
    logic          found_q, found_d;
    logic          hit;

    // Unsigned compare; target of zero can never be beaten.
    assign hit = (hash_q < target);

    // Next-state and datapath updates; everything holds unless a state acts.
    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        nonce_d     = nonce_q;
        header_d    = header_q;
        hash_d      = hash_q;
        nonce_out_d = nonce_out_q;
        found_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = FETCH;
                    rd_ptr_d = 2'd0;
                    nonce_d  = 32'd0;
                end
            end
            // rd_ptr is stable here; the memory registers the word at the end
            FETCH: state_d = LOAD;
            LOAD: begin
                header_d = entrada;
                state_d  = ISSUE;
            end
            ISSUE: begin
                if (hash_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (hash_done) begin
                    hash_d  = hash_out[23:16];
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (hit || (nonce_q == NONCE_LIMIT)) begin
                    if (hit) begin
                        nonce_out_d = nonce_q;
                        found_d     = 1'b1;
                    end
                    if (rd_ptr_q == LAST_PTR) begin
                        state_d = FINISH;
                    end else begin
                        rd_ptr_d = rd_ptr_q + 2'd1;
                        nonce_d  = 32'd0;
                        state_d  = FETCH;
                    end
                end else begin
                    // Same header, next nonce; no refetch needed.
                    nonce_d = nonce_q + 32'd1;
                    state_d = ISSUE;
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q     <= IDLE;
            rd_ptr_q    <= 2'd0;
            nonce_q     <= 32'd0;
            header_q    <= 96'd0;
            hash_q      <= 8'd0;
            nonce_out_q <= 32'd0;
            found_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            nonce_q     <= nonce_d;
            header_q    <= header_d;
            hash_q      <= hash_d;
            nonce_out_q <= nonce_out_d;
            found_q     <= found_d;
        end
    end

    assign rd_ptr       = rd_ptr_q;
    assign bloque_in    = {header_q, nonce_q};
    assign bloque_valid = (state_q == ISSUE);
    assign nonce_out    = nonce_out_q;
    assign found        = found_q;
    assign done         = (state_q == FINISH);
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_nonce_block_builder.sv
// Directed bench for nonce_block_builder: a default-parameter instance driven
// step by step, plus a NONCE_LIMIT=3 instance with an always-ready hash core.
module tb_nonce_block_builder;

    logic         clk = 1'b0;
    logic         reset_L;
    logic         start;
    logic [95:0]  entrada;
    logic         hash_ready;
    logic         hash_done;
    logic [23:0]  hash_out;
    logic [7:0]   target;
    logic [1:0]   rd_ptr;
    logic [127:0] bloque_in;
    logic         bloque_valid;
    logic [31:0]  nonce_out;
    logic         found;
    logic         done;
    logic         busy;

    logic         start2 = 1'b0;
    logic [95:0]  entrada2;
    logic         hash_ready2 = 1'b1;
    logic         hash_done2 = 1'b0;
    logic [23:0]  hash_out2 = 24'h00FFFF;
    logic [7:0]   target2 = 8'h00;
    logic [1:0]   rd_ptr2;
    logic [127:0] bloque_in2;
    logic         bloque_valid2;
    logic [31:0]  nonce_out2;
    logic         found2;
    logic         done2;
    logic         busy2;

    logic [95:0]  mem [4];
    int           vecs = 0;
    int           errs = 0;
    int           req2 = 0;
    int           nfound2 = 0;
    int           ndone2 = 0;

    always #5 clk = ~clk;

    nonce_block_builder dut (
        .clk(clk), .reset_L(reset_L), .start(start), .entrada(entrada),
        .hash_ready(hash_ready), .hash_done(hash_done), .hash_out(hash_out),
        .target(target), .rd_ptr(rd_ptr), .bloque_in(bloque_in),
        .bloque_valid(bloque_valid), .nonce_out(nonce_out), .found(found),
        .done(done), .busy(busy)
    );

    nonce_block_builder #(.NONCE_LIMIT(32'd3), .NUM_WORDS(4)) dut_l3 (
        .clk(clk), .reset_L(reset_L), .start(start2), .entrada(entrada2),
        .hash_ready(hash_ready2), .hash_done(hash_done2), .hash_out(hash_out2),
        .target(target2), .rd_ptr(rd_ptr2), .bloque_in(bloque_in2),
        .bloque_valid(bloque_valid2), .nonce_out(nonce_out2), .found(found2),
        .done(done2), .busy(busy2)
    );

    // Upstream memories: registered read, word valid one cycle after rd_ptr
    always @(posedge clk) entrada  <= mem[rd_ptr];
    always @(posedge clk) entrada2 <= mem[rd_ptr2];

    // Always-ready hash core for the second instance: digest one cycle after acceptance
    always @(posedge clk) hash_done2 <= bloque_valid2 & hash_ready2;

    function automatic logic [95:0] hdr(input int i);
        return mem[i[1:0]];
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Second instance: expected request n is word n/4 with nonce n%4
    always @(negedge clk) begin
        if (bloque_valid2) begin
            chk("l3 bloque_in", bloque_in2, 128'({hdr(req2 >> 2), 32'(req2 % 4)}));
            req2++;
        end
        if (found2) nfound2++;
        if (done2) ndone2++;
    end

    // Wait for an offer, check it, optionally stall, accept, optionally return a digest
    task automatic serve(input string tag, input logic [7:0] hb, input int hold, input bit poke,
                         input bit give_done, input logic [31:0] exp_nonce, input logic [95:0] exp_hdr);
        int t;
        t = 0;
        while (bloque_valid !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk({tag, " valid"}, 128'(bloque_valid), 128'(1));
        chk({tag, " bloque_in"}, bloque_in, {exp_hdr, exp_nonce});
        for (int i = 0; i < hold; i++) begin
            hash_ready = 1'b0;
            if (poke && i == 3) start = 1'b1;
            if (poke && i == 5) begin
                hash_done = 1'b1;
                hash_out  = 24'h001111;
            end
            @(negedge clk);
            start     = 1'b0;
            hash_done = 1'b0;
            hash_out  = 24'h0;
            chk({tag, " hold valid"}, 128'(bloque_valid), 128'(1));
            chk({tag, " hold data"}, bloque_in, {exp_hdr, exp_nonce});
        end
        hash_ready = 1'b1;
        @(negedge clk);
        hash_ready = 1'b0;
        chk({tag, " valid drop"}, 128'(bloque_valid), 128'(0));
        if (give_done) begin
            @(negedge clk);
            hash_out  = {hb, 16'h5A3C};
            hash_done = 1'b1;
            @(negedge clk);
            hash_done = 1'b0;
            hash_out  = 24'h0;
        end
    endtask

    initial begin
        int t;
        mem[0] = 96'h397d9f2f40ca9e6c6b1f3324;
        mem[1] = 96'hba23491e0f98ed0e2e3128e1;
        mem[2] = 96'hed18be0f984ae0e2e3128efe;
        mem[3] = 96'h8a7b78d8e9f789f3d89ec7c7;
        reset_L = 1'b0; start = 1'b0; hash_ready = 1'b0; hash_done = 1'b0;
        hash_out = 24'h0; target = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst busy", 128'(busy), 128'(0));
        chk("rst valid", 128'(bloque_valid), 128'(0));
        chk("rst bloque_in", bloque_in, 128'(0));
        chk("rst rd_ptr", 128'(rd_ptr), 128'(0));
        chk("rst nonce_out", 128'(nonce_out), 128'(0));
        chk("rst found", 128'(found), 128'(0));
        chk("rst done", 128'(done), 128'(0));
        reset_L = 1'b1;
        @(negedge clk);

        // Every word hits at nonce 0; start-to-valid latency of 3 cycles
        target = 8'h01;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("lat fetch busy", 128'(busy), 128'(1));
        chk("lat fetch valid", 128'(bloque_valid), 128'(0));
        @(negedge clk);
        chk("lat load valid", 128'(bloque_valid), 128'(0));
        @(negedge clk);
        chk("lat issue valid", 128'(bloque_valid), 128'(1));
        chk("first bloque_in", bloque_in, 128'h397d9f2f40ca9e6c6b1f3324_00000000);
        for (int w = 0; w < 4; w++) begin
            serve("allhit", 8'h00, 0, 1'b0, 1'b1, 32'h0, hdr(w));
            @(negedge clk);
            chk("allhit found", 128'(found), 128'(1));
            chk("allhit nonce_out", 128'(nonce_out), 128'(0));
            chk("allhit done", 128'(done), 128'(w == 3));
            chk("allhit rd_ptr", 128'(rd_ptr), 128'((w == 3) ? 3 : w + 1));
        end
        @(negedge clk);
        chk("allhit idle busy", 128'(busy), 128'(0));
        chk("allhit done gone", 128'(done), 128'(0));
        chk("allhit found gone", 128'(found), 128'(0));

        // Word 0 hits only at nonce 5, word 1 at nonce 1, reset while waiting on word 2
        target = 8'h10;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("r2 rd_ptr restart", 128'(rd_ptr), 128'(0));
        for (int n = 0; n < 6; n++) begin
            serve("n5", (n == 5) ? 8'h00 : 8'hFF, 0, 1'b0, 1'b1, 32'(n), hdr(0));
            @(negedge clk);
            chk("n5 found", 128'(found), 128'(n == 5));
        end
        chk("n5 nonce_out", 128'(nonce_out), 128'(5));
        chk("n5 rd_ptr", 128'(rd_ptr), 128'(1));
        for (int n = 0; n < 2; n++) begin
            serve("w1", (n == 1) ? 8'h0F : 8'h10, 0, 1'b0, 1'b1, 32'(n), hdr(1));
            @(negedge clk);
            chk("w1 found", 128'(found), 128'(n == 1));
        end
        chk("w1 nonce_out", 128'(nonce_out), 128'(1));
        chk("w1 rd_ptr", 128'(rd_ptr), 128'(2));
        serve("w2", 8'h00, 0, 1'b0, 1'b0, 32'h0, hdr(2));
        chk("w2 busy in wait", 128'(busy), 128'(1));
        reset_L = 1'b0;
        #1;
        chk("midrst busy", 128'(busy), 128'(0));
        chk("midrst rd_ptr", 128'(rd_ptr), 128'(0));
        chk("midrst bloque_in", bloque_in, 128'(0));
        chk("midrst nonce_out", 128'(nonce_out), 128'(0));
        chk("midrst valid", 128'(bloque_valid), 128'(0));
        @(negedge clk);
        reset_L = 1'b1;
        hash_out = 24'h000000;
        hash_done = 1'b1;
        @(negedge clk);
        hash_done = 1'b0;
        chk("stale done busy", 128'(busy), 128'(0));
        @(negedge clk);
        chk("stale done found", 128'(found), 128'(0));
        chk("stale done done", 128'(done), 128'(0));

        // Restart: stalled acceptance with start and hash_done poked during the stall
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("r3 rd_ptr", 128'(rd_ptr), 128'(0));
        serve("stall", 8'h00, 10, 1'b1, 1'b1, 32'h0, hdr(0));
        @(negedge clk);
        chk("stall found", 128'(found), 128'(1));
        chk("stall rd_ptr", 128'(rd_ptr), 128'(1));
        for (int w = 1; w < 4; w++) begin
            serve("r3", 8'h00, 0, 1'b0, 1'b1, 32'h0, hdr(w));
            @(negedge clk);
            chk("r3 found", 128'(found), 128'(1));
        end
        chk("r3 done", 128'(done), 128'(1));
        @(negedge clk);
        chk("r3 idle", 128'(busy), 128'(0));

        // NONCE_LIMIT=3 instance with target 0: four misses per word, no hits
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        t = 0;
        while (ndone2 == 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        chk("l3 requests", 128'(req2), 128'(16));
        chk("l3 found count", 128'(nfound2), 128'(0));
        chk("l3 done count", 128'(ndone2), 128'(1));
        chk("l3 busy after", 128'(busy2), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/nonce_block_builder.md
NONCE_BLOCK_BUILDER -- requirements
Module: nonce_block_builder

Interface
REQ-001 Parameter NONCE_LIMIT, default 32'h0000_00FF, last nonce tried per header word.
REQ-002 Parameter NUM_WORDS, default 4, header words per run; pointer range 0..NUM_WORDS-1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_L  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse; begins a run when idle.
REQ-006 entrada  input  96  header word from the upstream memory; registered there, valid one cycle after rd_ptr is sampled.
REQ-007 hash_ready  input  1  hash core accepts bloque_in when high together with bloque_valid.
REQ-008 hash_done  input  1  one-cycle pulse; hash_out valid in that cycle.
REQ-009 hash_out  input  24  digest from hash core.
REQ-010 target  input  8  difficulty threshold; stable during a run.
REQ-011 rd_ptr  output  2  header word index driven to upstream memory.
REQ-012 bloque_in  output  128  {captured header[95:0], nonce[31:0]} to hash core.
REQ-013 bloque_valid  output  1  bloque_in offered to hash core.
REQ-014 nonce_out  output  32  winning nonce of the last hit.
REQ-015 found  output  1  one-cycle pulse on a hit.
REQ-016 done  output  1  one-cycle pulse when the run completes.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 FSM states: IDLE, FETCH, LOAD, ISSUE, WAIT, CHECK, FINISH.
REQ-019 IDLE: start=1 -> FETCH, rd_ptr<=0, nonce<=0; start ignored in all other states.
REQ-020 FETCH: rd_ptr held one cycle -> LOAD.
REQ-021 LOAD: header register <= entrada at end of cycle -> ISSUE.
REQ-022 ISSUE: bloque_valid=1, bloque_in stable; bloque_valid & hash_ready -> WAIT; bloque_valid drops the cycle after acceptance.
REQ-023 WAIT: hash_done=1 -> CHECK, hash_out captured; hash_done outside WAIT ignored.
REQ-024 Hit rule: hash_out[23:16] < target, unsigned; target=0 never hits.
REQ-025 CHECK, hit: nonce_out<=nonce, found=1 for one cycle, advance word.
REQ-026 CHECK, miss and nonce==NONCE_LIMIT: advance word, no found.
REQ-027 CHECK, miss and nonce<NONCE_LIMIT: nonce<=nonce+1 -> ISSUE (header not refetched).
REQ-028 Advance word: rd_ptr==NUM_WORDS-1 -> FINISH; else rd_ptr<=rd_ptr+1, nonce<=0 -> FETCH.
REQ-029 FINISH: done=1 for one cycle -> IDLE; rd_ptr held.
REQ-030 Nonce increment never wraps; NONCE_LIMIT=32'hFFFF_FFFF terminates at REQ-026.
REQ-031 One outstanding hash request maximum; no new bloque_valid before CHECK.
REQ-032 Latency: start to first bloque_valid = 3 cycles (FETCH, LOAD, ISSUE asserted).

Reset
REQ-033 reset_L=0 asynchronously forces IDLE; rd_ptr=0, bloque_in=0, bloque_valid=0, nonce_out=0, found=0, done=0, busy=0, internal nonce/header=0.
REQ-034 Reset mid-run abandons the run; no found/done pulse; a pending hash_done after release is ignored (IDLE).

Verification
REQ-035 Reset, start, memory words {397d9f2f40ca9e6c6b1f3324, ba23491e0f98ed0e2e3128e1, ed18be0f984ae0e2e3128efe, 8a7b78d8e9f789f3d89ec7c7}, hash_out[23:16]=8'h00 with target=8'h01 -> four found pulses, nonce_out=0 each, first bloque_in=128'h397d9f2f40ca9e6c6b1f3324_00000000, then done.
REQ-036 Hash model returning 8'h00 only for nonce 5, target=8'h10 on word 0 -> bloque_in nonces 0..5 issued, found with nonce_out=32'h5, rd_ptr moves to 1.
REQ-037 target=0, NONCE_LIMIT=3 -> exactly 4 requests per word, 16 total, no found, done once, busy low after.
REQ-038 hash_ready held low 10 cycles in ISSUE -> bloque_valid and bloque_in stable throughout, single acceptance.
REQ-039 reset_L pulsed low during WAIT on word 2 -> all outputs zero immediately; later hash_done ignored; new start restarts at rd_ptr=0, nonce=0.
REQ-040 start pulsed while busy -> no effect on rd_ptr, nonce, or state sequence.
